adpcm_main_fir_acc: RTL and testbench

Streaming accumulate-and-scale stage that consumes the signed products of the ADPCM predictor's 32s×15ns pipelined multiplier and reduces each tap group to one predictor term. It sits directly downstream of the multiplier. It sums a group of products (coefficient × delayed sample) terminated by `in_last`, arithmetically shifts the sum right by the coefficient scale, and saturates it to 32 bits. It holds the result in a one-entry output register under a valid/ready handshake.

---
 rtl/adpcm_main_fir_acc.sv | 153 +++++++++++++++
 tb/tb_adpcm_main_fir_acc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_main_fir_acc.sv
// Accumulate-and-scale stage for the ADPCM predictor: sums a tap group of products, shifts by the
// coefficient scale, saturates, and holds one result. Define ADPCM_FIR_ACC_ROUND_EN for round-half-up.
module adpcm_main_fir_acc #(
    parameter int PROD_WIDTH = 47,
    parameter int ACC_WIDTH  = 52,
    parameter int SHIFT      = 14,
    parameter int OUT_WIDTH  = 32,
    parameter int MAX_TAPS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  out_overrun
);

    localparam int CNT_W = $clog2(MAX_TAPS + 1);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_TAPS - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
    localparam logic signed [ACC_WIDTH-1:0] C_ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam logic signed [ACC_WIDTH-1:0] C_OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                        r_state;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_out_valid;
    logic [OUT_WIDTH-1:0]          r_out_data;
    logic                          r_out_sat;
    logic                          r_out_overrun;

    logic                          w_in_fire;
    logic                          w_out_fire;
    logic                          w_closing;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   w_pre_shift;
    logic signed [ACC_WIDTH-1:0]   w_shifted;
    logic [OUT_WIDTH-1:0]          w_sat_data;
    logic                          w_sat_flag;

    // Returns {clipped, value} with the scaled sum clamped to the signed output range.
    function automatic logic [OUT_WIDTH:0] f_saturate(input logic signed [ACC_WIDTH-1:0] val);
        logic [OUT_WIDTH:0] res;
        if (val > C_OUT_MAX) begin
            res = {1'b1, C_OUT_MAX[OUT_WIDTH-1:0]};
        end else if (val < C_OUT_MIN) begin
            res = {1'b1, C_OUT_MIN[OUT_WIDTH-1:0]};
        end else begin
            res = {1'b0, val[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    assign in_ready   = ce & ((r_state != S_FULL) | out_ready);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = ce & r_out_valid & out_ready;
    assign w_closing  = in_last | (r_cnt == C_LAST_CNT);

    // Datapath: add the incoming product, scale by the coefficient shift, clamp to OUT_WIDTH.
    always_comb begin
        w_sum = r_acc + {{(ACC_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
`ifdef ADPCM_FIR_ACC_ROUND_EN
        w_pre_shift = w_sum + {{(ACC_WIDTH-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
`else
        w_pre_shift = w_sum;
`endif
        w_shifted = w_pre_shift >>> SHIFT;
        {w_sat_flag, w_sat_data} = f_saturate(w_shifted);
    end

    // Group state machine with the one-entry result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_acc         <= C_ACC_ZERO;
            r_cnt         <= C_CNT_ZERO;
            r_out_valid   <= 1'b0;
            r_out_data    <= {OUT_WIDTH{1'b0}};
            r_out_sat     <= 1'b0;
            r_out_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_in_fire && w_closing) begin
                        r_state       <= S_FULL;
                        r_acc         <= C_ACC_ZERO;
                        r_cnt         <= C_CNT_ZERO;
                        r_out_valid   <= 1'b1;
                        r_out_data    <= w_sat_data;
                        r_out_sat     <= w_sat_flag;
                        r_out_overrun <= ~in_last;
                    end else if (w_in_fire) begin
                        r_state <= S_ACC;
                        r_acc   <= w_sum;
                        r_cnt   <= r_cnt + C_CNT_ONE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_FULL: begin
                    // An input beat can only be accepted here in the same cycle the result drains.
                    if (w_in_fire && w_closing) begin
                        r_state       <= S_FULL;
                        r_acc         <= C_ACC_ZERO;
                        r_cnt         <= C_CNT_ZERO;
                        r_out_valid   <= 1'b1;
                        r_out_data    <= w_sat_data;
                        r_out_sat     <= w_sat_flag;
                        r_out_overrun <= ~in_last;
                    end else if (w_in_fire) begin
                        r_state     <= S_ACC;
                        r_acc       <= w_sum;
                        r_cnt       <= r_cnt + C_CNT_ONE;
                        r_out_valid <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= S_FULL;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_acc       <= C_ACC_ZERO;
                    r_cnt       <= C_CNT_ZERO;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_sat     = r_out_sat;
    assign out_overrun = r_out_overrun;

endmodule

// File: tb/tb_adpcm_main_fir_acc.sv
// Randomized and directed bench for adpcm_main_fir_acc against a group-level arithmetic model.
module tb_adpcm_main_fir_acc;
    localparam int PW = 47;
    localparam int OW = 32;
    localparam int SH = 14;
    localparam int MT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ce = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_prod = '0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic          out_overrun;

    int     n_checks = 0;
    int     n_pass = 0;
    longint cur_p = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_pend = 0;
    longint m_data = 0;
    bit     m_sat = 0;
    bit     m_ovr = 0;
    bit     e_rdy;

    adpcm_main_fir_acc dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_overrun(out_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Floor (or round-half-up) division of the group sum by 2^SHIFT.
    function automatic longint scale(input longint s);
        longint d, v, q;
        d = 1;
        d = d << SH;
        v = s;
`ifdef ADPCM_FIR_ACC_ROUND_EN
        v = v + d / 2;
`endif
        q = v / d;
        if (v < 0 && q * d != v) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        m_sum = 0; m_cnt = 0; m_pend = 0; m_data = 0; m_sat = 0; m_ovr = 0;
    endtask

    task automatic model_step();
        bit rdy;
        longint q;
        if (!reset) begin
            model_clear();
        end else begin
            rdy = ce && (!m_pend || out_ready);
            if (ce && m_pend && out_ready) m_pend = 0;
            if (rdy && in_valid) begin
                m_sum += cur_p;
                m_cnt++;
                if (in_last || m_cnt == MT) begin
                    q = scale(m_sum);
                    if (q > 64'sd2147483647) begin
                        m_data = 64'sd2147483647; m_sat = 1;
                    end else if (q < -64'sd2147483648) begin
                        m_data = -64'sd2147483648; m_sat = 1;
                    end else begin
                        m_data = q; m_sat = 0;
                    end
                    m_ovr = !in_last;
                    m_pend = 1;
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic set_in(input longint p, input bit v, input bit l, input bit c, input bit r);
        cur_p = p;
        in_prod = p[PW-1:0];
        in_valid = v;
        in_last = l;
        ce = c;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Compare every registered output and in_ready against the model mid-cycle.
    always @(negedge clk) begin
        e_rdy = ce && (!m_pend || out_ready);
        chk("in_ready", longint'(in_ready), longint'(e_rdy));
        chk("out_valid", longint'(out_valid), longint'(m_pend));
        chk("out_data", $signed(out_data), m_data);
        chk("out_sat", longint'(out_sat), longint'(m_sat));
        chk("out_overrun", longint'(out_overrun), longint'(m_ovr));
    end

    initial begin
        longint big;
        longint t;
        longint p;
        big = 1;
        big = big << 46;

        repeat (2) tick();
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_data", $signed(out_data), 0);
        reset = 1'b1;
        set_in(0, 0, 0, 1, 1);
        tick();

        set_in(16384, 1, 0, 1, 1); tick();
        set_in(32768, 1, 0, 1, 1); tick();
        set_in(-16384, 1, 1, 1, 1); tick();
        chk("t1_valid", longint'(out_valid), 1);
        chk("t1_data", $signed(out_data), 2);
        chk("t1_sat", longint'(out_sat), 0);
        chk("t1_ovr", longint'(out_overrun), 0);
        set_in(0, 0, 0, 1, 1); tick();

        set_in(8192, 1, 1, 1, 1); tick();
`ifdef ADPCM_FIR_ACC_ROUND_EN
        chk("t2_half", $signed(out_data), 1);
`else
        chk("t2_half", $signed(out_data), 0);
`endif
        set_in(-8193, 1, 1, 1, 1); tick();
        chk("t2_neg", $signed(out_data), -1);
        set_in(0, 0, 0, 1, 1); tick();

        set_in(big - 1, 1, 0, 1, 1); tick();
        set_in(big - 1, 1, 1, 1, 1); tick();
        chk("t3_max", $signed(out_data), 64'sd2147483647);
        chk("t3_max_sat", longint'(out_sat), 1);
        set_in(-big, 1, 0, 1, 1); tick();
        set_in(-big, 1, 1, 1, 1); tick();
        chk("t3_min", $signed(out_data), -64'sd2147483648);
        chk("t3_min_sat", longint'(out_sat), 1);
        set_in(0, 0, 0, 1, 1); tick();

        for (int i = 0; i < MT; i++) begin
            set_in(16384, 1, 0, 1, 1); tick();
        end
        chk("t4_valid", longint'(out_valid), 1);
        chk("t4_data", $signed(out_data), 16);
        chk("t4_ovr", longint'(out_overrun), 1);
        set_in(16384, 1, 1, 1, 1); tick();
        chk("t4_next", $signed(out_data), 1);
        chk("t4_next_ovr", longint'(out_overrun), 0);
        set_in(0, 0, 0, 1, 1); tick();

        set_in(16384, 1, 1, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(32768, 1, 1, 1, 0);
            #1;
            chk("t5_stall_rdy", longint'(in_ready), 0);
            tick();
            chk("t5_hold", $signed(out_data), 1);
        end
        set_in(32768, 1, 1, 1, 1); tick();
        chk("t5_b2b_valid", longint'(out_valid), 1);
        chk("t5_b2b_data", $signed(out_data), 2);
        set_in(0, 0, 0, 1, 1); tick();

        set_in(32768, 1, 1, 1, 0); tick();
        set_in(0, 0, 0, 1, 0);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        chk("t6_rst_valid", longint'(out_valid), 0);
        chk("t6_rst_data", $signed(out_data), 0);
        tick();
        reset = 1'b1;
        set_in(16384, 1, 0, 1, 1); tick();
        set_in(16384, 1, 0, 1, 1); tick();
        set_in(0, 0, 0, 1, 1);
        reset = 1'b0;
        model_clear();
        #1;
        chk("t6_mid_valid", longint'(out_valid), 0);
        tick();
        reset = 1'b1;
        set_in(16384, 1, 1, 1, 1); tick();
        chk("t6_after", $signed(out_data), 1);
        set_in(0, 0, 0, 1, 1); tick();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                model_clear();
            end else begin
                reset = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                t = {$urandom, $urandom};
                p = t >>> 17;
            end else begin
                p = longint'(int'($urandom_range(0, 65535)) - 32768);
            end
            set_in(p, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 9) < 9, $urandom_range(0, 9) < 7);
            tick();
        end

        set_in(0, 0, 0, 1, 1);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
